// File: rtl/sim_lane_pkg.sv
// sim_lane_pkg: shared types and constants for the serial lane loopback model.
//   state_e       - config FSM states (IDLE accepts writes, FLUSH drains lanes)
//   DEF_LANES     - default number of looped-back lanes
//   DEF_MAX_SKEW  - default maximum per-lane delay in clk cycles
//   LANE_W        - width of the cfg_lane index port
package sim_lane_pkg;
    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    localparam int DEF_LANES    = 8;
    localparam int DEF_MAX_SKEW = 15;
    localparam int LANE_W       = 5;
endpackage

// File: rtl/sim_lane_delay.sv
// sim_lane_delay: one loopback lane.
//   clk, rstn      - clock, asynchronous active-low reset
//   clr_i          - synchronous clear of the delay line; also forces the output idle
//   din_p_i/din_n_i- source lane bits (already lane-mapped)
//   skew_i         - tap select; output lags the input by 1+skew_i cycles
//   invert_i       - swap p/n on the output
//   fault_i        - force the output to 0/0 without disturbing the delay line
//   dout_p_o/dout_n_o - lane output
module sim_lane_delay #(
    parameter int MAX_SKEW = 15,
    parameter int SKEW_W   = $clog2(MAX_SKEW + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr_i,
    input  logic              din_p_i,
    input  logic              din_n_i,
    input  logic [SKEW_W-1:0] skew_i,
    input  logic              invert_i,
    input  logic              fault_i,
    output logic              dout_p_o,
    output logic              dout_n_o
);

    // Bit k holds the input sampled k+1 edges ago.
    logic [MAX_SKEW:0] sr_p_q;
    logic [MAX_SKEW:0] sr_n_q;
    logic              tap_p;
    logic              tap_n;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr_p_q <= '0;
            sr_n_q <= '0;
        end else if (clr_i) begin
            sr_p_q <= '0;
            sr_n_q <= '0;
        end else begin
            sr_p_q <= {sr_p_q[MAX_SKEW-1:0], din_p_i};
            sr_n_q <= {sr_n_q[MAX_SKEW-1:0], din_n_i};
        end
    end

    // skew_i is saturated to MAX_SKEW by the config logic, so the tap is in range.
    assign tap_p = sr_p_q[skew_i];
    assign tap_n = sr_n_q[skew_i];

    // Swapping p/n is a no-op when both are equal, so electrical idle passes
    // through untouched regardless of invert_i.
    always_comb begin
        dout_p_o = invert_i ? tap_n : tap_p;
        dout_n_o = invert_i ? tap_p : tap_n;
        if (clr_i || fault_i) begin
            dout_p_o = 1'b0;
            dout_n_o = 1'b0;
        end
    end

endmodule

// File: rtl/sim_lane_loop.sv
// sim_lane_loop: serial lane loopback with per-lane skew, polarity invert,
// global lane reversal and a forced electrical-idle fault injector.
//   clk, rstn                 - clock, asynchronous active-low reset
//   tx_p/tx_n                 - DUT transmit lanes
//   rx_p/rx_n                 - DUT receive lanes (delayed, mapped, optionally inverted)
//   cfg_valid/cfg_ready       - config write handshake
//   cfg_lane/cfg_skew/cfg_invert/cfg_reverse - write payload
//   cfg_err                   - one-cycle pulse after a write to a nonexistent lane
//   fault_start/fault_len     - start (or retrigger) a forced idle of fault_len cycles
//   fault_active              - forced idle in progress
module sim_lane_loop
    import sim_lane_pkg::*;
#(
    parameter int LANES    = DEF_LANES,
    parameter int MAX_SKEW = DEF_MAX_SKEW,
    parameter int SKEW_W   = $clog2(MAX_SKEW + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [LANES-1:0]  tx_p,
    input  logic [LANES-1:0]  tx_n,
    output logic [LANES-1:0]  rx_p,
    output logic [LANES-1:0]  rx_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [LANE_W-1:0] cfg_lane,
    input  logic [SKEW_W-1:0] cfg_skew,
    input  logic              cfg_invert,
    input  logic              cfg_reverse,
    output logic              cfg_err,
    input  logic              fault_start,
    input  logic [15:0]       fault_len,
    output logic              fault_active
);

    localparam logic [SKEW_W-1:0] SKEW_MAX = SKEW_W'(MAX_SKEW);

    state_e                        state_q;
    logic [SKEW_W-1:0]             fl_cnt_q;
    logic [LANES-1:0]              fmask_q;
    logic [LANES-1:0][SKEW_W-1:0]  skew_q;
    logic [LANES-1:0]              inv_q;
    logic                          rev_q;
    logic                          err_q;
    logic [15:0]                   fcnt_q;
    logic [15:0]                   fcnt_d;

    logic                          lane_ok;
    logic                          wr_ok;
    logic                          wr_bad;
    logic [SKEW_W-1:0]             skew_sat;
    logic [LANES-1:0]              flush_mask;
    logic [LANES-1:0]              lane_flush;

    assign cfg_ready    = (state_q == IDLE);
    assign cfg_err      = err_q;
    assign fault_active = (fcnt_q != 16'd0);

    assign lane_ok  = (int'(cfg_lane) < LANES);
    assign wr_ok    = cfg_valid && cfg_ready && lane_ok;
    assign wr_bad   = cfg_valid && cfg_ready && !lane_ok;
    assign skew_sat = (cfg_skew > SKEW_MAX) ? SKEW_MAX : cfg_skew;

    // A change of reversal remaps every lane, so every lane must be drained.
    always_comb begin
        flush_mask = '0;
        if (cfg_reverse != rev_q) begin
            flush_mask = '1;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (cfg_lane == LANE_W'(i)) flush_mask[i] = 1'b1;
            end
        end
    end

    // Config FSM. FLUSH runs MAX_SKEW+1 cycles: long enough to clear the
    // deepest tap before the new mapping/skew becomes visible.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            fl_cnt_q <= '0;
            fmask_q  <= '0;
            skew_q   <= '0;
            inv_q    <= '0;
            rev_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= wr_bad;
            case (state_q)
                IDLE: begin
                    if (wr_ok) begin
                        state_q  <= FLUSH;
                        fl_cnt_q <= SKEW_MAX;
                        fmask_q  <= flush_mask;
                        rev_q    <= cfg_reverse;
                        for (int i = 0; i < LANES; i++) begin
                            if (cfg_lane == LANE_W'(i)) begin
                                skew_q[i] <= skew_sat;
                                inv_q[i]  <= cfg_invert;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (fl_cnt_q == '0) state_q <= IDLE;
                    else                fl_cnt_q <= fl_cnt_q - SKEW_W'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Fault down-counter; a new nonzero length always reloads, zero is ignored.
    always_comb begin
        fcnt_d = fcnt_q;
        if (fault_start && (fault_len != 16'd0)) fcnt_d = fault_len;
        else if (fcnt_q != 16'd0)                fcnt_d = fcnt_q - 16'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) fcnt_q <= 16'd0;
        else       fcnt_q <= fcnt_d;
    end

    assign lane_flush = {LANES{state_q == FLUSH}} & fmask_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        localparam int SRC_REV = LANES - 1 - g;
        logic din_p;
        logic din_n;

        assign din_p = rev_q ? tx_p[SRC_REV] : tx_p[g];
        assign din_n = rev_q ? tx_n[SRC_REV] : tx_n[g];

        sim_lane_delay #(
            .MAX_SKEW (MAX_SKEW),
            .SKEW_W   (SKEW_W)
        ) u_lane (
            .clk      (clk),
            .rstn     (rstn),
            .clr_i    (lane_flush[g]),
            .din_p_i  (din_p),
            .din_n_i  (din_n),
            .skew_i   (skew_q[g]),
            .invert_i (inv_q[g]),
            .fault_i  (fault_active),
            .dout_p_o (rx_p[g]),
            .dout_n_o (rx_n[g])
        );
    end

endmodule

// File: tb/tb_sim_lane_loop.sv
module tb_sim_lane_loop;
    localparam int L  = 8;
    localparam int MS = 15;
    localparam int SW = 4;
    localparam int HN = 8192;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [L-1:0]  tx_p = '0, tx_n = '0;
    logic [L-1:0]  rx_p, rx_n;
    logic          cfg_valid = 1'b0, cfg_ready;
    logic [4:0]    cfg_lane = '0;
    logic [SW-1:0] cfg_skew = '0;
    logic          cfg_invert = 1'b0, cfg_reverse = 1'b0, cfg_err;
    logic          fault_start = 1'b0;
    logic [15:0]   fault_len = '0;
    logic          fault_active;

    always #5 clk = ~clk;

    sim_lane_loop dut (
        .clk(clk), .rstn(rstn), .tx_p(tx_p), .tx_n(tx_n), .rx_p(rx_p), .rx_n(rx_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_lane(cfg_lane),
        .cfg_skew(cfg_skew), .cfg_invert(cfg_invert), .cfg_reverse(cfg_reverse),
        .cfg_err(cfg_err), .fault_start(fault_start), .fault_len(fault_len),
        .fault_active(fault_active)
    );

    int n_chk = 0, n_fail = 0;
    int cyc = 0;

    // Reference model: tx history by cycle plus current config and time stamps.
    logic [L-1:0] hp [HN];
    logic [L-1:0] hn [HN];
    int           m_skew [L];
    bit           m_inv [L];
    int           m_lastclr [L];   // samples taken at or before this cycle are gone
    bit           m_rev;
    int           m_fl;            // flush cycles remaining, including the current one
    bit [L-1:0]   m_mask;
    bit           m_err;
    int           m_until;         // last cycle of forced idle

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic exp_rx(output logic [L-1:0] ep, output logic [L-1:0] en);
        int s, src;
        for (int i = 0; i < L; i++) begin
            ep[i] = 1'b0;
            en[i] = 1'b0;
            s = cyc - 1 - m_skew[i];
            if (cyc > m_until && !(m_fl > 0 && m_mask[i]) && s > m_lastclr[i]) begin
                src = m_rev ? L - 1 - i : i;
                ep[i] = m_inv[i] ? hn[s][src] : hp[s][src];
                en[i] = m_inv[i] ? hp[s][src] : hn[s][src];
            end
        end
    endtask

    task automatic check_cycle();
        logic [L-1:0] ep, en;
        exp_rx(ep, en);
        chk("rx_p", rx_p, ep);
        chk("rx_n", rx_n, en);
        chk("cfg_ready", cfg_ready, m_fl == 0);
        chk("cfg_err", cfg_err, m_err);
        chk("fault_active", fault_active, cyc <= m_until);
    endtask

    task automatic model_reset();
        for (int i = 0; i < L; i++) begin
            m_skew[i] = 0; m_inv[i] = 0; m_lastclr[i] = cyc - 1;
        end
        m_rev = 0; m_fl = 0; m_mask = '0; m_err = 0; m_until = -1;
    endtask

    // Apply the current inputs for one clock, advance the model, check outputs.
    task automatic tick();
        bit acc;
        hp[cyc] = tx_p;
        hn[cyc] = tx_n;
        acc = cfg_valid && (m_fl == 0);
        if (acc && cfg_lane < L) begin
            m_mask = (cfg_reverse != m_rev) ? '1 : (L'(1) << cfg_lane);
            m_skew[cfg_lane] = (cfg_skew > MS) ? MS : int'(cfg_skew);
            m_inv[cfg_lane]  = cfg_invert;
            m_rev = cfg_reverse;
            m_fl  = MS + 1;
            for (int i = 0; i < L; i++) if (m_mask[i]) m_lastclr[i] = cyc + MS + 1;
        end else if (m_fl > 0) begin
            m_fl--;
        end
        m_err = acc && (cfg_lane >= L);
        if (fault_start && fault_len != 0) m_until = cyc + int'(fault_len);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic do_reset();
        cfg_valid = 0; fault_start = 0;
        #2 rstn = 1'b0;
        #1;
        chk("rst_rx_p", rx_p, 0);
        chk("rst_rx_n", rx_n, 0);
        chk("rst_fault", fault_active, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_err", cfg_err, 0);
        repeat (2) begin @(posedge clk); cyc++; end
        @(negedge clk);
        model_reset();
        check_cycle();
        rstn = 1'b1;
    endtask

    task automatic cfg_set(input int lane, input int skew, input bit inv, input bit rev);
        cfg_valid = 1; cfg_lane = 5'(lane); cfg_skew = SW'(skew);
        cfg_invert = inv; cfg_reverse = rev;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!cfg_ready && n < 40) begin tick(); n++; end
        chk(tag, cfg_ready, 1);
    endtask

    // Caller drives the pulse; returns the cycle count until it shows on rx_p[lane].
    task automatic lat(input string tag, input int lane, input int exp_k);
        int k = 0, got = -1;
        while (k < 40 && got < 0) begin
            tick();
            if (k == 0) begin tx_p = '0; tx_n = '0; end
            k++;
            if (rx_p[lane]) got = k;
        end
        chk(tag, got, exp_k);
    endtask

    task automatic zeros(input int n);
        tx_p = '0; tx_n = '0;
        repeat (n) tick();
    endtask

    initial begin
        int cnt;
        cyc = 16;
        @(negedge clk);
        do_reset();

        // Walking pattern at zero skew.
        tx_p = 8'hA5; tx_n = 8'h5A; tick();
        chk("walk_p", rx_p, 8'hA5);
        chk("walk_n", rx_n, 8'h5A);
        tx_p = 8'h3C; tx_n = 8'hC3; tick();

        // Skew write on lane 3; count the flush window with random traffic.
        cfg_set(3, 7, 0, 0); tick(); cfg_valid = 0;
        cnt = 0;
        while (!cfg_ready && cnt < 40) begin
            tx_p = L'($urandom); tx_n = L'($urandom); tick(); cnt++;
        end
        chk("flush_len", cnt, MS + 1);
        zeros(2);
        tx_p = 8'h08; lat("skew7_lat", 3, 8);
        zeros(2);
        tx_p = 8'h04; lat("lane2_lat", 2, 1);

        // Reverse plus invert on lane 0 (reverse change flushes all lanes).
        zeros(1);
        cfg_set(0, 0, 1, 1); tick(); cfg_valid = 0;
        chk("rev_ready_low", cfg_ready, 0);
        tx_p = '0; tx_n = '0;
        wait_ready("rev_wait");
        tx_p = 8'h01; tx_n = 8'h00; tick();
        chk("rev_p7", rx_p[7], 1);
        chk("rev_n7", rx_n[7], 0);
        tx_p = 8'h80; tx_n = 8'h00; tick();
        chk("inv_p0", rx_p[0], 0);
        chk("inv_n0", rx_n[0], 1);
        tx_p = 8'hFF; tx_n = 8'hFF; tick();
        chk("idle_p0", rx_p[0], 1);
        chk("idle_n0", rx_n[0], 1);

        // Rejected write, then skew saturation.
        cfg_set(9, 3, 1, 0); tick(); cfg_valid = 0;
        chk("err_pulse", cfg_err, 1);
        chk("err_ready", cfg_ready, 1);
        tick();
        chk("err_clear", cfg_err, 0);
        cfg_set(5, 31, 0, 1); tick(); cfg_valid = 0;
        tx_p = '0; tx_n = '0;
        wait_ready("sat_wait");
        tx_p = 8'h04; lat("sat_lat", 5, MS + 1);

        // Fault length, retrigger, zero length.
        fault_start = 1; fault_len = 16'd20; tick(); fault_start = 0;
        cnt = 0;
        while (fault_active && cnt < 60) begin
            tx_p = L'($urandom); tx_n = L'($urandom); tick(); cnt++;
        end
        chk("fault_len20", cnt, 20);
        fault_start = 1; fault_len = 16'd20; tick(); fault_start = 0;
        cnt = 0;
        while (fault_active && cnt < 60) begin
            if (cnt == 9) begin fault_start = 1; fault_len = 16'd5; end
            tx_p = L'($urandom); tx_n = L'($urandom); tick();
            fault_start = 0;
            cnt++;
        end
        chk("fault_retrig", cnt, 15);
        fault_start = 1; fault_len = 16'd0; tick(); fault_start = 0;
        chk("fault_len0", fault_active, 0);

        // Simultaneous config write and fault start.
        cfg_set(1, 2, 0, 1); fault_start = 1; fault_len = 16'd3; tick();
        cfg_valid = 0; fault_start = 0;
        chk("sim_fault", fault_active, 1);
        chk("sim_ready", cfg_ready, 0);
        wait_ready("sim_wait");

        // Reset in the middle of a flush and a fault.
        cfg_set(4, 9, 1, 1); tick(); cfg_valid = 0;
        tx_p = 8'hFF; tx_n = 8'h00; repeat (3) tick();
        fault_start = 1; fault_len = 16'd50; tick(); fault_start = 0;
        repeat (2) tick();
        do_reset();
        tx_p = 8'hA5; tx_n = 8'h5A; tick();
        chk("rst_skew0_p", rx_p, 8'hA5);
        chk("rst_skew0_n", rx_n, 8'h5A);

        // Randomized traffic, config writes and faults.
        repeat (1500) begin
            tx_p = L'($urandom); tx_n = L'($urandom);
            cfg_valid   = ($urandom_range(0, 15) == 0);
            cfg_lane    = 5'($urandom_range(0, 10));
            cfg_skew    = SW'($urandom);
            cfg_invert  = 1'($urandom);
            cfg_reverse = ($urandom_range(0, 3) == 0) ? !m_rev : m_rev;
            fault_start = ($urandom_range(0, 59) == 0);
            fault_len   = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 30));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sim_lane_loop.md
SIM_LANE_LOOP -- requirements
Module: sim_lane_loop

Interface
REQ-001 Parameter LANES, default 8, number of serial lanes looped back (legal range 1..16).
REQ-002 Parameter MAX_SKEW, default 15, maximum per-lane delay in clk cycles (legal range 1..63).
REQ-003 Parameter SKEW_W, default $clog2(MAX_SKEW+1), width of the skew fields.
REQ-004 The ports SHALL be as follows (one clock; reset is asynchronous, active-low):
- clk  in  1  sampling clock, one bit per lane per cycle.
- rstn  in  1  asynchronous active-low reset.
- tx_p, tx_n  in  LANES  DUT transmit lanes.
- rx_p, rx_n  out  LANES  DUT receive lanes.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept.
- cfg_lane  in  5  target lane.
- cfg_skew  in  SKEW_W  lane delay.
- cfg_invert  in  1  lane polarity invert.
- cfg_reverse  in  1  global lane reversal, applied on every accepted write.
- cfg_err  out  1  one-cycle pulse on a rejected write.
- fault_start  in  1  pulse that starts forced electrical idle.
- fault_len  in  16  idle duration in cycles.
- fault_active  out  1  forced idle in progress.

Function
REQ-005 Source mapping: source lane for rx lane i SHALL be LANES-1-i when reverse=1, else i.
REQ-006 Data path: rx_p[i]/rx_n[i] SHALL equal the source tx_p/tx_n delayed by 1+skew[i] cycles (registered output).
REQ-007 Inversion: when invert[i]=1, the delayed p and n SHALL be swapped.
REQ-008 Electrical idle (tx_p==tx_n) SHALL pass through unchanged, with no inversion effect.
REQ-009 Config handshake: a write SHALL occur on a cycle with cfg_valid and cfg_ready both high.
REQ-010 cfg_ready SHALL be 1 in state IDLE and 0 in state FLUSH.
REQ-011 IDLE->FLUSH on an accepted write with cfg_lane<LANES; skew, invert and reverse SHALL update on the following cycle.
REQ-012 FLUSH SHALL last exactly MAX_SKEW+1 cycles, then return to IDLE. While in FLUSH, the target lane (and every lane, if reverse changed) SHALL output rx_p=rx_n=0, and its delay line SHALL be cleared.
REQ-013 Rejected write: cfg_lane>=LANES SHALL be accepted, SHALL change nothing, SHALL pulse cfg_err for one cycle the next cycle, and SHALL stay in IDLE.
REQ-014 Skew saturation: a cfg_skew value greater than MAX_SKEW SHALL be stored as MAX_SKEW.
REQ-015 Fault start: fault_start with fault_len!=0 SHALL load a down-counter; fault_active=1 from the next cycle for exactly fault_len cycles.
REQ-016 Fault retrigger: fault_start while fault_active SHALL reload the counter with the new length.
REQ-017 fault_start with fault_len=0 SHALL be ignored.
REQ-018 During fault_active, all rx_p and rx_n SHALL be 0. Delay lines SHALL keep shifting, so data resumes immediately when the fault ends.
REQ-019 Simultaneous cfg write and fault_start SHALL both take effect; fault forcing has priority on the outputs.

Reset
REQ-020 Asynchronous assertion of rstn SHALL clear, at any time including mid-FLUSH or mid-fault:
- all delay lines, rx_p and rx_n to 0;
- skew, invert and reverse to 0;
- cfg_err and fault_active to 0;
- the fault counter to 0;
- state to IDLE.
REQ-021 After rstn deasserts, cfg_ready SHALL be 1 on the first clk edge.

Structure
REQ-022 Package sim_lane_pkg SHALL hold:
- the state enum {IDLE, FLUSH};
- default LANES/MAX_SKEW constants;
- the lane-index width constant.
REQ-023 Sub-module sim_lane_delay SHALL implement one lane: a (MAX_SKEW+1)-deep p/n shift register with a variable tap and a synchronous clear. It SHALL be instantiated LANES times via generate.
REQ-024 Target size is 120-400 lines of RTL in total.

Verification
REQ-025 Reset then walking pattern: all skews 0, tx_p=8'hA5, tx_n=8'h5A -> rx_p=8'hA5, rx_n=8'h5A one cycle later.
REQ-026 Skew write: lane 3 with skew 7 -> cfg_ready low for 16 cycles and lane 3 idle (0/0) during that time; afterwards a single-cycle tx_p[3] pulse appears on rx_p[3] 8 cycles later, while other lanes stay at 1 cycle.
REQ-027 Reverse plus invert: reverse=1, invert lane 0 -> tx_p=8'h01 appears on rx lane 7 unswapped; tx_p=8'h80 appears on lane 0 as rx_p=0, rx_n=1.
REQ-028 Error and saturation: cfg_lane=9 with LANES=8 -> cfg_err single pulse, no change. cfg_skew=31 with MAX_SKEW=15 -> latency 16.
REQ-029 Fault: fault_len=20 -> all rx at 0/0 for exactly 20 cycles. Retrigger at cycle 10 with len 5 -> idle ends at cycle 15. fault_len=0 -> no effect.
REQ-030 Reset mid-operation: rstn asserted mid-FLUSH and mid-fault -> immediate zero outputs, cfg_ready=1 after release, skew back to 0.
